// File: rtl/sw_cond_pkg.sv
// Shared types and constants for the switch input-conditioning stage.
// Imported by the per-bit debouncer and the 3-bit top.
package sw_cond_pkg;

  typedef enum logic {
    DB_IDLE,
    DB_PENDING
  } db_state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int SW_WIDTH = 3;

endpackage

// File: rtl/sw_debounce3_bit.sv
// One-bit synchroniser plus debounce FSM.
// A level is accepted after DEBOUNCE_CYCLES consecutive mismatching edges.
module debounce_bit
  import sw_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic accept,
  output logic pending
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

  logic          s1;
  logic          s2;
  logic          mismatch;
  db_state_t     state_q;
  db_state_t     state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          stable_d;

  assign mismatch = s2 ^ stable;

  // Two-flop synchroniser, nothing between the flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // State, counter and accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      stable  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stable  <= stable_d;
    end
  end

  // Next state: start, extend, abandon or accept a pending change.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable;
    unique case (state_q)
      DB_IDLE: begin
        if (accept) begin
          stable_d = s2;
        end else if (mismatch) begin
          state_d = DB_PENDING;
          cnt_d   = CW'(1);
        end
      end
      DB_PENDING: begin
        if (!mismatch) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          state_d  = DB_IDLE;
          cnt_d    = '0;
          stable_d = s2;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Accept strobe on the Nth mismatching edge; pending while unaccepted.
  always_comb begin
    accept  = 1'b0;
    pending = 1'b0;
    unique case (state_q)
      DB_IDLE:    accept = mismatch && SINGLE;
      DB_PENDING: accept = mismatch && (cnt_q == LAST);
      default:    accept = 1'b0;
    endcase
    pending = mismatch && !SINGLE;
  end

endmodule

// File: rtl/sw_debounce3.sv
// Debounced, registered input vector for the 3-input decode stage.
// Emits one change strobe per accept edge, however many bits accept.
module sw_debounce3
  import sw_cond_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] in_clean,
  output logic             changed,
  output logic             busy
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] pend;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (raw_in[i]),
      .stable (in_clean[i]),
      .accept (acc[i]),
      .pending(pend[i])
    );
  end

  // Strobe lands with the new in_clean, one cycle wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) changed <= 1'b0;
    else        changed <= |acc;
  end

  assign busy = |pend;

endmodule
